vect_exec_ctrl: RTL and testbench
=================================

// Module: vect_exec_ctrl
// PURPOSE
//  Issue/hazard controller for the vector execute stage (execVect + ALUVect).
//  - Decides, per ID-stage instruction, the operand-mux selects Fa/Fb/Fc and immSrc.
//  - Detects load-use and multi-cycle-ALU hazards; stalls ID/holds EX as needed.
//  - Tracks the EX and MEM destination registers needed for forwarding.
//  - Sits between the decoder and the ID/EX pipeline register of the vector datapath.
// PARAMETERS
//  REGW    4   vector register address width (16 regs; reg 0 never forwards)
//  MC_LAT  3   EX occupancy in cycles of a multi-cycle ALU op (>=2)
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     synchronous, active-high reset
//  id_valid     in   1     valid instruction in ID
//  id_rs1       in   REGW  source reg for op1
//  id_rs2       in   REGW  source reg for op2
//  id_rs3       in   REGW  source reg for rd3 (store data / 3-op ops)
//  id_use_imm   in   1     op2 comes from imm (drives immSrc)
//  id_use_rs3   in   1     instruction reads rs3
//  id_rd        in   REGW  destination reg
//  id_we        in   1     instruction writes rd
//  id_is_load   in   1     vector load (result available only after MEM)
//  id_alu_ctl   in   4     aluControl; 4'b11xx = multi-cycle op
//  stall        out  1     freeze PC/IF/ID this cycle
//  ex_hold      out  1     freeze ID/EX register (multi-cycle op in EX)
//  ex_valid     out  1     EX holds a real instruction (0 = bubble)
//  ex_rd        out  REGW  EX destination reg
//  ex_we        out  1     EX write enable (0 on bubble)
//  Fa           out  1     EX op1 select: 1 = Forward1 (MEM result)
//  Fb           out  1     EX op2 forward select (with immSrc forms mux41 sel)
//  Fc           out  1     EX rd3 select: 1 = Forward3
//  immSrc       out  1     EX op2 immediate select
// BEHAVIOUR
//  - Reset (sync, priority over all): state=RUN; cnt=0; ex_valid=0; ex_we=0; ex_rd=0;
//    Fa=Fb=Fc=immSrc=0; MEM tracker mem_we=0, mem_is_load=0.
//    stall=0 and ex_hold=0 in the reset cycle.
//  - Latency: selects are computed in ID and registered into EX.
//    Fa/Fb/Fc/immSrc/ex_* are valid the cycle after issue.
//  - Forwarding source is the instruction one ahead, i.e. in EX at decision time.
//    match_x = id_valid & ex_valid & ex_we & ex_rd!=0 & ex_rd==id_rs_x.
//  - Regfile is write-before-read; WB-stage distances need no forwarding.
//  - Fa=match_1.
//  - Fb=match_2 & !id_use_imm. Fb=1 and immSrc=1 never coexist; mux41 sel 2'b11 is illegal.
//  - Fc=match_3 & id_use_rs3.
//  - Load-use: EX instr is a load and any used source matches -> stall=1 for 1 cycle.
//    ID/EX loads a bubble (ex_valid=0, ex_we=0, selects 0).
//    Next cycle the load is in MEM/WB; the instr re-evaluates with no EX match and reads the regfile.
//  - FSM states RUN, MC_BUSY:
//    RUN: issuing a multi-cycle op (id_alu_ctl[3:2]==2'b11, no load-use stall) -> MC_BUSY, cnt=MC_LAT-1.
//    MC_BUSY: stall=1, ex_hold=1; EX registers unchanged; cnt decrements each cycle.
//    MC_BUSY with cnt==1 -> RUN. The op occupies EX exactly MC_LAT cycles.
//    ID instruction waits; its selects are recomputed against the multi-cycle op on release.
//  - MEM tracker (ex_rd/ex_we/is_load shifted one stage) advances only when !ex_hold.
//    During MC_BUSY a bubble enters MEM each cycle except the first.
//  - Simultaneous load-use and multi-cycle request: load-use wins; multi-cycle starts after the bubble.
//  - id_valid=0: bubble into EX, no stall.
//  - rst mid-MC_BUSY: return to RUN next edge, EX emptied.
// STRUCTURE
//  - Package vect_ctrl_pkg holds:
//    typedef enum logic {RUN, MC_BUSY} vctrl_state_t;
//    localparam MC_OPMASK=4'b1100;
//    function is_multicycle(ctl).
//  - One sub-module vect_fwd_match: combinational rs-vs-ex_rd compare producing match_1/2/3 and load_use.
//  - FSM, counter and ID/EX registers live in the top.
// TESTING
//  1. Reset then id r3<-r1+r2 (rd=3,we) followed by r4<-r3+r3 -> next EX cycle Fa=1, Fb=1, stall never 1.
//  2. Load rd=5 then add rs1=5 -> exactly 1 stall cycle, 1 bubble (ex_valid=0), then add issues with Fa=0.
//  3. Multi-cycle op (ctl=4'b1100), MC_LAT=3 -> ex_hold=1 for 2 cycles; stall=1 for 2 cycles; op in EX 3 cycles.
//  4. Dependent instr after the multi-cycle op -> Fa=1 on release cycle; ID PC held throughout.
//  5. Imm op with rs2 matching ex_rd -> immSrc=1, Fb=0; rd=0 writer never forwards (Fa=0).
//  6. rst asserted in 2nd MC_BUSY cycle -> next cycle state RUN; ex_valid=0; stall=0; all selects 0.

Source files
------------

// File: rtl/vect_ctrl_pkg.sv
// Shared types and helpers for the vector execute-stage issue/hazard controller.
package vect_ctrl_pkg;

    typedef enum logic {RUN, MC_BUSY} vctrl_state_t;

    // aluControl codes matching this mask run on the multi-cycle ALU path
    localparam logic [3:0] MC_OPMASK = 4'b1100;

    function automatic logic is_multicycle(input logic [3:0] ctl);
        return (ctl & MC_OPMASK) == MC_OPMASK;
    endfunction

endpackage

// File: rtl/vect_fwd_match.sv
// Combinational compare of the ID sources against the instruction currently in EX.
module vect_fwd_match #(
    parameter int REGW = 4
) (
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rs3,
    input  logic            id_use_imm,
    input  logic            id_use_rs3,
    input  logic            ex_valid,
    input  logic            ex_we,
    input  logic            ex_is_load,
    input  logic [REGW-1:0] ex_rd,
    output logic            match_1,
    output logic            match_2,
    output logic            match_3,
    output logic            load_use
);

    logic ex_fwd;

    // EX can only supply a value when it really writes a non-zero register
    always_comb begin
        ex_fwd   = id_valid & ex_valid & ex_we & (ex_rd != '0);
        match_1  = ex_fwd & (ex_rd == id_rs1);
        match_2  = ex_fwd & (ex_rd == id_rs2);
        match_3  = ex_fwd & (ex_rd == id_rs3);
        // only sources the instruction actually reads can create a load-use hazard
        load_use = ex_is_load & (match_1 | (match_2 & ~id_use_imm) | (match_3 & id_use_rs3));
    end

endmodule

// File: rtl/vect_exec_ctrl.sv
// Issue/hazard controller: operand-forward selects, load-use bubbles and
// multi-cycle ALU occupancy for the vector execute stage.
module vect_exec_ctrl
    import vect_ctrl_pkg::*;
#(
    parameter int REGW   = 4,
    parameter int MC_LAT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rs3,
    input  logic            id_use_imm,
    input  logic            id_use_rs3,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_we,
    input  logic            id_is_load,
    input  logic [3:0]      id_alu_ctl,
    output logic            stall,
    output logic            ex_hold,
    output logic            ex_valid,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_we,
    output logic            Fa,
    output logic            Fb,
    output logic            Fc,
    output logic            immSrc
);

    localparam int CW = $clog2(MC_LAT) + 1;

    vctrl_state_t    state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ex_valid_q, ex_valid_d;
    logic [REGW-1:0] ex_rd_q, ex_rd_d;
    logic            ex_we_q, ex_we_d;
    logic            ex_is_load_q, ex_is_load_d;
    logic            fa_q, fa_d, fb_q, fb_d, fc_q, fc_d, imm_q, imm_d;
    logic [REGW-1:0] mem_rd_q, mem_rd_d;
    logic            mem_we_q, mem_we_d;
    logic            mem_is_load_q, mem_is_load_d;
    logic            match_1, match_2, match_3, load_use;
    logic            issue;

    vect_fwd_match #(.REGW(REGW)) u_match (
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rs3     (id_rs3),
        .id_use_imm (id_use_imm),
        .id_use_rs3 (id_use_rs3),
        .ex_valid   (ex_valid_q),
        .ex_we      (ex_we_q),
        .ex_is_load (ex_is_load_q),
        .ex_rd      (ex_rd_q),
        .match_1    (match_1),
        .match_2    (match_2),
        .match_3    (match_3),
        .load_use   (load_use)
    );

    // Next-state, ID/EX and MEM-tracker update; hold everything while the multi-cycle op drains
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ex_valid_d    = ex_valid_q;
        ex_rd_d       = ex_rd_q;
        ex_we_d       = ex_we_q;
        ex_is_load_d  = ex_is_load_q;
        fa_d          = fa_q;
        fb_d          = fb_q;
        fc_d          = fc_q;
        imm_d         = imm_q;
        mem_rd_d      = mem_rd_q;
        mem_we_d      = mem_we_q;
        mem_is_load_d = mem_is_load_q;
        stall         = 1'b0;
        ex_hold       = 1'b0;
        issue         = 1'b0;
        case (state_q)
            RUN: begin
                stall         = load_use;
                issue         = id_valid & ~load_use;
                mem_rd_d      = ex_rd_q;
                mem_we_d      = ex_we_q & (ex_rd_q != '0);
                mem_is_load_d = ex_is_load_q & ex_we_q & (ex_rd_q != '0);
                // a stalled or empty ID slot becomes a bubble with all selects cleared
                ex_valid_d    = issue;
                ex_rd_d       = issue ? id_rd : '0;
                ex_we_d       = issue & id_we;
                ex_is_load_d  = issue & id_is_load & id_we;
                fa_d          = issue & match_1;
                fb_d          = issue & match_2 & ~id_use_imm;
                fc_d          = issue & match_3 & id_use_rs3;
                imm_d         = issue & id_use_imm;
                if (issue && is_multicycle(id_alu_ctl)) begin
                    state_d = MC_BUSY;
                    cnt_d   = CW'(MC_LAT - 1);
                end
            end
            MC_BUSY: begin
                stall         = 1'b1;
                ex_hold       = 1'b1;
                // EX is frozen, so nothing new flows into MEM
                mem_rd_d      = '0;
                mem_we_d      = 1'b0;
                mem_is_load_d = 1'b0;
                cnt_d         = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (rst) begin
            stall   = 1'b0;
            ex_hold = 1'b0;
        end
    end

    // Pipeline and FSM registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            ex_valid_q    <= 1'b0;
            ex_rd_q       <= '0;
            ex_we_q       <= 1'b0;
            ex_is_load_q  <= 1'b0;
            fa_q          <= 1'b0;
            fb_q          <= 1'b0;
            fc_q          <= 1'b0;
            imm_q         <= 1'b0;
            mem_rd_q      <= '0;
            mem_we_q      <= 1'b0;
            mem_is_load_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ex_valid_q    <= ex_valid_d;
            ex_rd_q       <= ex_rd_d;
            ex_we_q       <= ex_we_d;
            ex_is_load_q  <= ex_is_load_d;
            fa_q          <= fa_d;
            fb_q          <= fb_d;
            fc_q          <= fc_d;
            imm_q         <= imm_d;
            mem_rd_q      <= mem_rd_d;
            mem_we_q      <= mem_we_d;
            mem_is_load_q <= mem_is_load_d;
        end
    end

    // MEM-stage and mux-select invariants
    a_mem_load_we: assert property (@(posedge clk) disable iff (rst) mem_is_load_q |-> mem_we_q);
    a_mem_rd_nz:   assert property (@(posedge clk) disable iff (rst) mem_we_q |-> (mem_rd_q != '0));
    a_mux_sel:     assert property (@(posedge clk) disable iff (rst) !(fb_q && imm_q));

    assign ex_valid = ex_valid_q;
    assign ex_rd    = ex_rd_q;
    assign ex_we    = ex_we_q;
    assign Fa       = fa_q;
    assign Fb       = fb_q;
    assign Fc       = fc_q;
    assign immSrc   = imm_q;

endmodule

// File: tb/tb_vect_exec_ctrl.sv
// Randomized bench for vect_exec_ctrl against an occupancy-based reference model.
module tb_vect_exec_ctrl;

    localparam int MC_LAT = 3;

    typedef struct {
        logic       v;
        logic [3:0] rs1, rs2, rs3, rd;
        logic       imm, u3, we, ld;
        logic [3:0] ctl;
    } ins_t;

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_use_imm, id_use_rs3, id_we, id_is_load;
    logic [3:0] id_rs1, id_rs2, id_rs3, id_rd, id_alu_ctl;
    logic stall, ex_hold, ex_valid, ex_we, Fa, Fb, Fc, immSrc;
    logic [3:0] ex_rd;

    int checks = 0;
    int errors = 0;

    // reference model: what sits in EX and how long it has been there
    logic       m_v, m_we, m_ld, m_mc, m_fa, m_fb, m_fc, m_imm;
    logic [3:0] m_rd;
    int         m_age;
    logic       last_stall;
    int         stall_seen;

    always #5 clk = ~clk;

    vect_exec_ctrl #(.REGW(4), .MC_LAT(MC_LAT)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs3(id_rs3), .id_use_imm(id_use_imm), .id_use_rs3(id_use_rs3), .id_rd(id_rd),
        .id_we(id_we), .id_is_load(id_is_load), .id_alu_ctl(id_alu_ctl), .stall(stall),
        .ex_hold(ex_hold), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_we(ex_we),
        .Fa(Fa), .Fb(Fb), .Fc(Fc), .immSrc(immSrc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ins_t mk(input logic v, input logic [3:0] rs1, rs2, rs3, rd,
                                input logic imm, u3, we, ld, input logic [3:0] ctl);
        ins_t i;
        i.v = v; i.rs1 = rs1; i.rs2 = rs2; i.rs3 = rs3; i.rd = rd;
        i.imm = imm; i.u3 = u3; i.we = we; i.ld = ld; i.ctl = ctl;
        return i;
    endfunction

    function automatic logic hit(input logic [3:0] r);
        return m_v && m_we && (m_rd != 4'd0) && (r == m_rd);
    endfunction

    // one clock: drive ID, check stall/hold before the edge, EX registers after it
    task automatic step(input logic r, input ins_t i);
        logic busy, haz, exp_stall;
        @(negedge clk);
        rst = r; id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rs3 = i.rs3;
        id_rd = i.rd; id_use_imm = i.imm; id_use_rs3 = i.u3; id_we = i.we;
        id_is_load = i.ld; id_alu_ctl = i.ctl;
        #1;
        busy = m_v && m_mc && (m_age < MC_LAT);
        haz  = !busy && i.v && m_ld &&
               (hit(i.rs1) || (!i.imm && hit(i.rs2)) || (i.u3 && hit(i.rs3)));
        exp_stall = !r && (busy || haz);
        chk("stall", stall, exp_stall);
        chk("ex_hold", ex_hold, !r && busy);
        if (stall) stall_seen++;
        last_stall = exp_stall;
        if (r || (!busy && !(i.v && !haz))) begin
            m_v = 0; m_rd = 0; m_we = 0; m_ld = 0; m_mc = 0;
            m_fa = 0; m_fb = 0; m_fc = 0; m_imm = 0; m_age = 0;
        end else if (busy) begin
            m_age++;
        end else begin
            m_fa  = hit(i.rs1);
            m_fb  = hit(i.rs2) && !i.imm;
            m_fc  = hit(i.rs3) && i.u3;
            m_imm = i.imm;
            m_v = 1; m_rd = i.rd; m_we = i.we; m_ld = i.ld;
            m_mc = (i.ctl[3:2] == 2'b11); m_age = 1;
        end
        @(posedge clk);
        #1;
        chk("ex_valid", ex_valid, m_v);
        chk("ex_rd", ex_rd, m_rd);
        chk("ex_we", ex_we, m_we);
        chk("Fa", Fa, m_fa);
        chk("Fb", Fb, m_fb);
        chk("Fc", Fc, m_fc);
        chk("immSrc", immSrc, m_imm);
    endtask

    ins_t idle, cur;

    initial begin
        m_v = 0; m_rd = 0; m_we = 0; m_ld = 0; m_mc = 0;
        m_fa = 0; m_fb = 0; m_fc = 0; m_imm = 0; m_age = 0;
        last_stall = 0; stall_seen = 0;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
        step(1, idle);
        step(1, idle);

        // dependent add chain forwards both operands
        step(0, mk(1, 1, 2, 0, 3, 0, 0, 1, 0, 4'h2));
        step(0, mk(1, 3, 3, 0, 4, 0, 0, 1, 0, 4'h2));
        chk("t1_fa", Fa, 1);
        chk("t1_fb", Fb, 1);

        // load-use: exactly one stall and one bubble, then no forward
        step(0, mk(1, 0, 0, 0, 5, 0, 0, 1, 1, 4'h0));
        stall_seen = 0;
        step(0, mk(1, 5, 1, 0, 8, 0, 0, 1, 0, 4'h2));
        chk("t2_bubble", ex_valid, 0);
        step(0, mk(1, 5, 1, 0, 8, 0, 0, 1, 0, 4'h2));
        chk("t2_stalls", stall_seen, 1);
        chk("t2_fa", Fa, 0);

        // multi-cycle op then dependent consumer held in ID
        step(0, mk(1, 1, 2, 0, 6, 0, 0, 1, 0, 4'hC));
        stall_seen = 0;
        for (int k = 0; k < MC_LAT; k++) step(0, mk(1, 6, 2, 0, 9, 0, 0, 1, 0, 4'h1));
        chk("t3_stalls", stall_seen, MC_LAT - 1);
        chk("t4_fa", Fa, 1);

        // immediate op ignores a matching rs2; rd=0 writer never forwards
        step(0, mk(1, 1, 1, 0, 7, 0, 0, 1, 0, 4'h2));
        step(0, mk(1, 2, 7, 0, 10, 1, 0, 1, 0, 4'h2));
        chk("t5_imm", immSrc, 1);
        chk("t5_fb", Fb, 0);
        step(0, mk(1, 1, 1, 0, 0, 0, 0, 1, 0, 4'h2));
        step(0, mk(1, 0, 0, 0, 11, 0, 0, 1, 0, 4'h2));
        chk("t5_fa_r0", Fa, 0);

        // reset during the second busy cycle empties EX
        step(0, mk(1, 1, 2, 0, 6, 0, 0, 1, 0, 4'hD));
        step(0, idle);
        step(1, idle);
        step(0, mk(1, 6, 6, 0, 2, 0, 0, 1, 0, 4'h2));
        chk("t6_fa", Fa, 0);

        // random traffic; a stalled instruction stays in ID
        cur = idle;
        for (int n = 0; n < 600; n++) begin
            logic r;
            if (!last_stall) begin
                cur = mk($urandom_range(99) < 85, 4'($urandom_range(3)), 4'($urandom_range(3)),
                         4'($urandom_range(3)), 4'($urandom_range(3)),
                         $urandom_range(3) == 0, $urandom_range(2) == 0,
                         $urandom_range(4) != 0, $urandom_range(3) == 0,
                         ($urandom_range(5) == 0) ? 4'($urandom_range(15) | 12) : 4'($urandom_range(11)));
            end
            r = ($urandom_range(99) == 0);
            step(r, cur);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
